// File: rtl/bnn_stream_loader.sv
// Streaming feature loader for a combinational BNN classifier.
// Assembles FEAT_CNT beats into a feature vector, waits SETTLE_CYCLES for the
// classifier to settle, then registers and holds its result until consumed.
module bnn_stream_loader #(
   parameter int unsigned FEAT_CNT      = 19,
   parameter int unsigned FEAT_BITS     = 4,
   parameter int unsigned CLASS_CNT     = 3,
   parameter int unsigned SETTLE_CYCLES = 2,
   localparam int unsigned CW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
   localparam int unsigned FW = FEAT_CNT * FEAT_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FEAT_BITS-1:0] in_data,
   input  logic                 in_last,
   output logic [FW-1:0]        features,
   input  logic [CW-1:0]        prediction,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_class,
   output logic                 frame_err,
   output logic [15:0]          sample_count
);

   localparam int unsigned BW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
   localparam logic [BW-1:0] LastBeat = BW'(FEAT_CNT - 1);
   localparam logic [7:0]    SettleLast = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StLoad, StSettle, StHold} state_e;

   state_e          state_q;
   logic [BW-1:0]   beat_cnt_q;
   logic [7:0]      settle_cnt_q;
   logic [FW-1:0]   features_q;
   logic            out_valid_q;
   logic [CW-1:0]   out_class_q;
   logic            frame_err_q;
   logic [15:0]     sample_count_q;

   logic            beat_acc;
   logic            is_final;
   logic            frame_bad;
   logic [FW-1:0]   features_shifted;

   // Gated by rst_n so the loader never advertises readiness while held in reset.
   assign in_ready = rst_n && (state_q == StLoad);

   // Beat acceptance and framing decode for the current beat.
   always_comb begin
      beat_acc         = in_valid && in_ready;
      is_final         = (beat_cnt_q == LastBeat);
      // Error when in_last disagrees with the beat position in either direction.
      frame_bad        = (in_last != is_final);
      features_shifted = (features_q << FEAT_BITS) | FW'(in_data);
   end

   // Control FSM with all datapath registers; outputs are registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= StLoad;
         beat_cnt_q     <= '0;
         settle_cnt_q   <= '0;
         features_q     <= '0;
         out_valid_q    <= 1'b0;
         out_class_q    <= '0;
         frame_err_q    <= 1'b0;
         sample_count_q <= '0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            StLoad: begin
               if (beat_acc) begin
                  // Malformed beats still shift in; a full good frame overwrites them.
                  features_q <= features_shifted;
                  if (frame_bad) begin
                     frame_err_q <= 1'b1;
                     beat_cnt_q  <= '0;
                  end else if (is_final) begin
                     beat_cnt_q   <= '0;
                     settle_cnt_q <= '0;
                     state_q      <= StSettle;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            StSettle: begin
               if (settle_cnt_q == SettleLast) begin
                  out_class_q <= prediction;
                  out_valid_q <= 1'b1;
                  state_q     <= StHold;
               end else begin
                  settle_cnt_q <= settle_cnt_q + 8'd1;
               end
            end
            StHold: begin
               if (out_ready) begin
                  out_valid_q    <= 1'b0;
                  sample_count_q <= sample_count_q + 16'd1;
                  state_q        <= StLoad;
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   assign features     = features_q;
   assign out_valid    = out_valid_q;
   assign out_class    = out_class_q;
   assign frame_err    = frame_err_q;
   assign sample_count = sample_count_q;

endmodule
